// File: rtl/edge_stretcher_multi.sv
// Multi-channel edge detector and pulse stretcher.
// Each channel synchronises its input, detects edges per a shared mode and stretches them.
module edge_stretcher_multi #(
  parameter int N_CH        = 4,
  parameter int N_CLOCK     = 125000000,
  parameter int CNT_W       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] inp,
  input  logic [1:0]      edge_mode,
  input  logic            retrig,
  input  logic            clr_ovr,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] edge_pulse,
  output logic [N_CH-1:0] overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CLOCK - 1);

  logic [SYNC_STAGES-1:0] sync [N_CH];
  state_t                 state [N_CH];
  logic [CNT_W-1:0]       cnt [N_CH];

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] det;
  logic [N_CH-1:0] drop;

  always_comb begin
    rise = '0;
    fall = '0;
    det  = '0;
    drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise[i] = sync[i][SYNC_STAGES-2] & ~sync[i][SYNC_STAGES-1];
      fall[i] = ~sync[i][SYNC_STAGES-2] & sync[i][SYNC_STAGES-1];
      case (edge_mode)
        2'b00:   det[i] = rise[i];
        2'b01:   det[i] = fall[i];
        2'b10:   det[i] = rise[i] | fall[i];
        default: det[i] = 1'b0;
      endcase
      // An edge landing on the final count is a fresh trigger, not a drop.
      drop[i] = det[i] & (state[i] == ACTIVE) & ~retrig & (cnt[i] != LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        sync[i]  <= '0;
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      out        <= '0;
      edge_pulse <= '0;
      overrun    <= '0;
    end else begin
      edge_pulse <= det;
      overrun    <= drop | (overrun & ~{N_CH{clr_ovr}});
      for (int i = 0; i < N_CH; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], inp[i]};
        unique case (state[i])
          IDLE: begin
            if (det[i]) begin
              out[i]   <= 1'b1;
              cnt[i]   <= '0;
              state[i] <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (cnt[i] == LAST) begin
              cnt[i] <= '0;
              if (!det[i]) begin
                out[i]   <= 1'b0;
                state[i] <= IDLE;
              end
            end else if (det[i] && retrig) begin
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_stretcher_multi.sv
// Bench for edge_stretcher_multi: vector table, directed corner sequences
// and a random run against a remaining-cycles reference model.
module tb_edge_stretcher_multi;

  localparam int NC = 4;
  localparam int NK = 5;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] inp = '0;
  logic [1:0]    edge_mode = 2'b00;
  logic          retrig = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [NC-1:0] out;
  logic [NC-1:0] edge_pulse;
  logic [NC-1:0] overrun;

  edge_stretcher_multi #(
    .N_CH(NC), .N_CLOCK(NK), .CNT_W(3), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .inp(inp), .edge_mode(edge_mode),
    .retrig(retrig), .clr_ovr(clr_ovr), .out(out),
    .edge_pulse(edge_pulse), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: remaining high cycles per channel and raw sample history.
  int            rem [NC];
  logic          hist [NC][SS];
  logic [NC-1:0] m_out = '0;
  logic [NC-1:0] m_ep = '0;
  logic [NC-1:0] m_ovr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic r, f, d, s;
    for (int c = 0; c < NC; c++) begin
      if (!reset) begin
        rem[c] = 0;
        for (int k = 0; k < SS; k++) hist[c][k] = 1'b0;
        m_ep[c] = 1'b0;
        m_ovr[c] = 1'b0;
      end else begin
        r = hist[c][SS-2] & !hist[c][SS-1];
        f = !hist[c][SS-2] & hist[c][SS-1];
        case (edge_mode)
          2'b00:   d = r;
          2'b01:   d = f;
          2'b10:   d = r | f;
          default: d = 1'b0;
        endcase
        for (int k = SS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = inp[c];
        s = 1'b0;
        if (d && (rem[c] <= 1 || retrig)) begin
          rem[c] = NK;
        end else begin
          if (d) s = 1'b1;
          if (rem[c] > 0) rem[c]--;
        end
        m_ep[c] = d;
        m_ovr[c] = s | (m_ovr[c] & !clr_ovr);
      end
      m_out[c] = (rem[c] > 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("edge_pulse", 32'(edge_pulse), 32'(m_ep));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    inp = '0;
    clr_ovr = 1'b0;
    for (int j = 0; j < n; j++) step();
  endtask

  // Drive channel 0 from a bit pattern; report out high cycles, strobes, first high step.
  task automatic run_seq(input logic [31:0] pat, input int len,
                         input int clr_idx, output int hi,
                         output int eps, output int first);
    hi = 0;
    eps = 0;
    first = -1;
    for (int j = 0; j < len; j++) begin
      inp = {{(NC-1){1'b0}}, pat[j]};
      clr_ovr = (j == clr_idx);
      step();
      if (out[0]) begin
        hi++;
        if (first < 0) first = j;
      end
      if (edge_pulse[0]) eps++;
    end
    clr_ovr = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic [NC-1:0] in;
    logic [NC-1:0] eo;
    logic [NC-1:0] ee;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int hi, eps, first;
    for (int c = 0; c < NC; c++) begin
      rem[c] = 0;
      for (int k = 0; k < SS; k++) hist[c][k] = 1'b0;
    end

    // Reset, then a single rising edge on channel 0 with a 5-cycle pulse.
    tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{1'b1, 4'h1, 4'h0, 4'h0};
    tbl[6]  = '{1'b1, 4'h1, 4'h1, 4'h1};
    tbl[7]  = '{1'b1, 4'h1, 4'h1, 4'h0};
    tbl[8]  = '{1'b1, 4'h1, 4'h1, 4'h0};
    tbl[9]  = '{1'b1, 4'h1, 4'h1, 4'h0};
    tbl[10] = '{1'b1, 4'h1, 4'h1, 4'h0};
    tbl[11] = '{1'b1, 4'h1, 4'h0, 4'h0};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      inp = tbl[i].in;
      step();
      chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_ep", i), 32'(edge_pulse), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'h0);
    end
    idle(4);

    edge_mode = 2'b01;
    idle(2);
    run_seq(32'h0000_03FF, 30, -1, hi, eps, first);
    chk("fall_hi", 32'(hi), 32'd5);
    chk("fall_ep", 32'(eps), 32'd1);
    chk("fall_first", 32'(first), 32'd11);

    edge_mode = 2'b10;
    idle(2);
    run_seq(32'h0000_03FF, 30, -1, hi, eps, first);
    chk("both_hi", 32'(hi), 32'd10);
    chk("both_ep", 32'(eps), 32'd2);

    edge_mode = 2'b11;
    idle(2);
    run_seq(32'h0000_03FF, 30, -1, hi, eps, first);
    chk("off_hi", 32'(hi), 32'd0);
    chk("off_ep", 32'(eps), 32'd0);

    edge_mode = 2'b00;
    retrig = 1'b1;
    idle(4);
    run_seq(32'h0000_00FB, 16, -1, hi, eps, first);
    chk("retrig_hi", 32'(hi), 32'd8);
    chk("retrig_first", 32'(first), 32'd1);
    chk("retrig_ovr", 32'(overrun[0]), 32'd0);

    retrig = 1'b0;
    idle(4);
    run_seq(32'h0000_00FB, 16, -1, hi, eps, first);
    chk("drop_hi", 32'(hi), 32'd5);
    chk("drop_ovr", 32'(overrun[0]), 32'd1);
    idle(5);
    chk("drop_sticky", 32'(overrun[0]), 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("drop_clr", 32'(overrun[0]), 32'd0);
    idle(3);

    run_seq(32'h0000_00EF, 20, -1, hi, eps, first);
    chk("term_hi", 32'(hi), 32'd10);
    chk("term_first", 32'(first), 32'd1);
    chk("term_ovr", 32'(overrun[0]), 32'd0);
    idle(4);

    run_seq(32'h0000_00FB, 16, 4, hi, eps, first);
    chk("setwins_ovr", 32'(overrun[0]), 32'd1);
    clr_ovr = 1'b1;
    step();
    idle(4);

    inp = 4'h1;
    step();
    step();
    step();
    chk("mid_pre", 32'(out[0]), 32'd1);
    reset = 1'b0;
    step();
    chk("mid_rst", 32'(out), 32'd0);
    reset = 1'b1;
    idle(4);

    inp = 4'h1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    run_seq(32'hFFFF_FFFF, 12, -1, hi, eps, first);
    chk("hold_hi", 32'(hi), 32'd5);
    chk("hold_ep", 32'(eps), 32'd1);
    idle(8);

    for (int j = 0; j < 3000; j++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 7) == 0) inp[c] = ~inp[c];
      if ($urandom_range(0, 49) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) retrig = ~retrig;
      clr_ovr = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
